// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_e   : controller FSM states (S_RUN, S_MUL)
//   action_e  : winning hazard action of the current cycle
//   FWD_*     : forward-select encodings shared with the forwarding unit
//   load_use_hit() : load-use dependency detector
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_MUL = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_LOADUSE = 3'd1,
    ACT_MUL     = 3'd2,
    ACT_BRANCH  = 3'd3,
    ACT_DMISS   = 3'd4
  } action_e;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_controller_if
// Bundles the hazard inputs from the pipeline and the stall/flush controls and
// performance counters returned by the hazard controller.
//   master : pipeline side (drives in_*, receives out_*)
//   slave  : hazard controller side (receives in_*, drives out_*)
// Parameter CNT_W : width of the performance counter outputs.
// -----------------------------------------------------------------------------
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic             in_IDEX_mem_read;
  logic [4:0]       in_IDEX_rd;
  logic [4:0]       in_IFID_rs1;
  logic [4:0]       in_IFID_rs2;
  logic             in_IDEX_is_mul;
  logic             in_EX_branch_taken;
  logic             in_dcache_stall;

  logic             out_stall_fetch;
  logic             out_stall_decode;
  logic             out_stall_execute;
  logic             out_stall_memory;
  logic             out_flush_decode;
  logic             out_flush_execute;
  logic             out_flush_memory;
  logic             out_flush_writeback;
  logic             out_mul_busy;
  logic [CNT_W-1:0] out_cnt_loaduse;
  logic [CNT_W-1:0] out_cnt_mul;
  logic [CNT_W-1:0] out_cnt_dmiss;
  logic [CNT_W-1:0] out_cnt_flush;

  modport master (
    output in_IDEX_mem_read, in_IDEX_rd, in_IFID_rs1, in_IFID_rs2,
           in_IDEX_is_mul, in_EX_branch_taken, in_dcache_stall,
    input  out_stall_fetch, out_stall_decode, out_stall_execute, out_stall_memory,
           out_flush_decode, out_flush_execute, out_flush_memory, out_flush_writeback,
           out_mul_busy, out_cnt_loaduse, out_cnt_mul, out_cnt_dmiss, out_cnt_flush
  );

  modport slave (
    input  in_IDEX_mem_read, in_IDEX_rd, in_IFID_rs1, in_IFID_rs2,
           in_IDEX_is_mul, in_EX_branch_taken, in_dcache_stall,
    output out_stall_fetch, out_stall_decode, out_stall_execute, out_stall_memory,
           out_flush_decode, out_flush_execute, out_flush_memory, out_flush_writeback,
           out_mul_busy, out_cnt_loaduse, out_cnt_mul, out_cnt_dmiss, out_cnt_flush
  );
endinterface

// File: rtl/hazard_perf_counters.sv
// -----------------------------------------------------------------------------
// hazard_perf_counters
// Four free-running event counters, one per hazard action. Each increments in
// every cycle in which its action wins; counters wrap modulo 2^CNT_W.
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset (clears all counters)
//   act_i         in   winning action of the current cycle
//   cnt_loaduse_o out  load-use stall cycles
//   cnt_mul_o     out  MUL stall cycles
//   cnt_dmiss_o   out  D-cache miss stall cycles
//   cnt_flush_o   out  taken-branch flush cycles
// Instantiated by hazard_controller only when HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module hazard_perf_counters
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  action_e          act_i,
  output logic [CNT_W-1:0] cnt_loaduse_o,
  output logic [CNT_W-1:0] cnt_mul_o,
  output logic [CNT_W-1:0] cnt_dmiss_o,
  output logic [CNT_W-1:0] cnt_flush_o
);

  logic [3:0]       hit;
  logic [CNT_W-1:0] cnt_q [4];

  assign hit = {act_i == ACT_BRANCH, act_i == ACT_DMISS, act_i == ACT_MUL, act_i == ACT_LOADUSE};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q[gi] <= '0;
      end else if (hit[gi]) begin
        cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
      end
    end
  end

  assign cnt_loaduse_o = cnt_q[0];
  assign cnt_mul_o     = cnt_q[1];
  assign cnt_dmiss_o   = cnt_q[2];
  assign cnt_flush_o   = cnt_q[3];

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline. Resolves the hazards
// forwarding cannot cover (D-cache miss, multi-cycle MUL, taken branch,
// load-use) and drives per-stage hold/bubble controls.
// Ports:
//   clk    in     clock, rising edge
//   reset  in     asynchronous active-low reset; all outputs 0 while low
//   hz     slave  hazard_controller_if: hazard inputs, stall/flush outputs,
//                 mul_busy and performance counters
// Parameters:
//   MUL_LATENCY  cycles a MUL occupies EX (>=1, 1 = no stall)
//   CNT_W        performance counter width
// Macro HAZARD_PERF_CNT_EN: when defined, instantiates hazard_perf_counters;
// otherwise the counter outputs are tied to 0.
// -----------------------------------------------------------------------------
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                reset,
  hazard_controller_if.slave hz
);

  localparam int  MC_W       = $clog2(MUL_LATENCY) + 1;
  localparam bit  MUL_STALLS = (MUL_LATENCY > 1);
  // Entry cycle is the first stall, the final S_MUL cycle (count 0) releases.
  localparam int  MUL_INIT   = MUL_STALLS ? (MUL_LATENCY - 2) : 0;

  state_e           state_q, state_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  action_e          act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Next state and winning action, highest priority first.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    act       = ACT_NONE;
    if (hz.in_dcache_stall) begin
      // Whole pipe frozen; FSM holds so a MUL or branch resumes afterwards.
      act = ACT_DMISS;
    end else if (state_q == S_MUL) begin
      if (mul_cnt_q != '0) begin
        act       = ACT_MUL;
        mul_cnt_d = mul_cnt_q - MC_W'(1);
      end else begin
        state_d = S_RUN;
      end
    end else if (hz.in_IDEX_is_mul && MUL_STALLS) begin
      act       = ACT_MUL;
      state_d   = S_MUL;
      mul_cnt_d = MC_W'(MUL_INIT);
    end else if (hz.in_EX_branch_taken) begin
      act = ACT_BRANCH;
    end else if (load_use_hit(hz.in_IDEX_mem_read, hz.in_IDEX_rd,
                              hz.in_IFID_rs1, hz.in_IFID_rs2)) begin
      act = ACT_LOADUSE;
    end
  end

  // Control decode; forced to 0 while reset is asserted.
  always_comb begin
    hz.out_stall_fetch     = 1'b0;
    hz.out_stall_decode    = 1'b0;
    hz.out_stall_execute   = 1'b0;
    hz.out_stall_memory    = 1'b0;
    hz.out_flush_decode    = 1'b0;
    hz.out_flush_execute   = 1'b0;
    hz.out_flush_memory    = 1'b0;
    hz.out_flush_writeback = 1'b0;
    hz.out_mul_busy        = 1'b0;
    if (reset) begin
      hz.out_mul_busy = (state_q == S_MUL);
      case (act)
        ACT_DMISS: begin
          hz.out_stall_fetch     = 1'b1;
          hz.out_stall_decode    = 1'b1;
          hz.out_stall_execute   = 1'b1;
          hz.out_stall_memory    = 1'b1;
          hz.out_flush_writeback = 1'b1;
        end
        ACT_MUL: begin
          // MUL stays in EX; a bubble goes downstream into EX/MEM.
          hz.out_stall_fetch   = 1'b1;
          hz.out_stall_decode  = 1'b1;
          hz.out_stall_execute = 1'b1;
          hz.out_flush_memory  = 1'b1;
        end
        ACT_BRANCH: begin
          hz.out_flush_decode  = 1'b1;
          hz.out_flush_execute = 1'b1;
        end
        ACT_LOADUSE: begin
          hz.out_stall_fetch   = 1'b1;
          hz.out_stall_decode  = 1'b1;
          hz.out_flush_execute = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .reset        (reset),
    .act_i        (act),
    .cnt_loaduse_o(hz.out_cnt_loaduse),
    .cnt_mul_o    (hz.out_cnt_mul),
    .cnt_dmiss_o  (hz.out_cnt_dmiss),
    .cnt_flush_o  (hz.out_cnt_flush)
  );
`else
  assign hz.out_cnt_loaduse = {CNT_W{1'b0}};
  assign hz.out_cnt_mul     = {CNT_W{1'b0}};
  assign hz.out_cnt_dmiss   = {CNT_W{1'b0}};
  assign hz.out_cnt_flush   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed-vector bench for hazard_controller (MUL_LATENCY=4, CNT_W=32).
// Outputs are packed as {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
// flush_m, flush_wb, mul_busy}. Counter expectations depend on
// HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(32)) hz ();

  hazard_controller #(
    .MUL_LATENCY(4),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  localparam logic [8:0] O_NONE = 9'b000000000;
  localparam logic [8:0] O_LU   = 9'b110001000;
  localparam logic [8:0] O_MULE = 9'b111000100;
  localparam logic [8:0] O_MULB = 9'b111000101;
  localparam logic [8:0] O_MULR = 9'b000000001;
  localparam logic [8:0] O_DM   = 9'b111100010;
  localparam logic [8:0] O_DMB  = 9'b111100011;
  localparam logic [8:0] O_BR   = 9'b000011000;

  int checks = 0;
  int errors = 0;
  int exp_lu = 0, exp_mul = 0, exp_dm = 0, exp_br = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {hz.out_stall_fetch, hz.out_stall_decode, hz.out_stall_execute, hz.out_stall_memory,
            hz.out_flush_decode, hz.out_flush_execute, hz.out_flush_memory,
            hz.out_flush_writeback, hz.out_mul_busy};
  endfunction

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mul, input logic br, input logic dc);
    hz.in_IDEX_mem_read   = mr;
    hz.in_IDEX_rd         = rd;
    hz.in_IFID_rs1        = rs1;
    hz.in_IFID_rs2        = rs2;
    hz.in_IDEX_is_mul     = mul;
    hz.in_EX_branch_taken = br;
    hz.in_dcache_stall    = dc;
  endtask

  // Check this cycle's outputs (inputs already driven), then advance one clock.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #2;
    $display("txn %-10s out=%b exp=%b", tag, outs(), exp);
    check_val(tag, 64'(outs()), 64'(exp));
    if (exp == O_LU) exp_lu++;
    if (exp == O_MULE || exp == O_MULB) exp_mul++;
    if (exp == O_DM || exp == O_DMB) exp_dm++;
    if (exp == O_BR) exp_br++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int lu, input int mu, input int dm, input int br);
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, "_lu"},  64'(hz.out_cnt_loaduse), 64'(lu));
    check_val({tag, "_mul"}, 64'(hz.out_cnt_mul),     64'(mu));
    check_val({tag, "_dm"},  64'(hz.out_cnt_dmiss),   64'(dm));
    check_val({tag, "_br"},  64'(hz.out_cnt_flush),   64'(br));
`else
    check_val({tag, "_lu"},  64'(hz.out_cnt_loaduse), 64'(lu) & 64'd0);
    check_val({tag, "_mul"}, 64'(hz.out_cnt_mul),     64'(mu) & 64'd0);
    check_val({tag, "_dm"},  64'(hz.out_cnt_dmiss),   64'(dm) & 64'd0);
    check_val({tag, "_br"},  64'(hz.out_cnt_flush),   64'(br) & 64'd0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    check_val("rst_outs", 64'(outs()), 64'(O_NONE));
    check_cnts("rst", 0, 0, 0, 0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: load x5, add x6,x5,x1
    set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0); cyc("lu_rs1", O_LU);
    set_in(1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0); cyc("lu_bubble", O_NONE);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("lu_x0", O_NONE);
    set_in(1'b1, 5'd5, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0); cyc("lu_nodep", O_NONE);
    set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0); cyc("lu_rs2", O_LU);

    // MUL latency 4: three stall cycles, release on the fourth
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); cyc("mul_entry", O_MULE);
    cyc("mul_s1", O_MULB);
    cyc("mul_s2", O_MULB);
    cyc("mul_rel", O_MULR);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("mul_after", O_NONE);

    // D-cache miss for 3 cycles while S_MUL with mul_cnt=1
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); cyc("dm_entry", O_MULE);
    cyc("dm_mul1", O_MULB);
    hz.in_dcache_stall = 1'b1;
    cyc("dm_hold0", O_DMB);
    cyc("dm_hold1", O_DMB);
    cyc("dm_hold2", O_DMB);
    hz.in_dcache_stall = 1'b0;
    cyc("dm_mul2", O_MULB);
    cyc("dm_rel", O_MULR);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("dm_after", O_NONE);

    // Branch priorities
    set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1, 1'b0); cyc("br_lu", O_BR);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("br_dm", O_DM);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("br_retry", O_BR);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("idle", O_NONE);

    #2;
    check_cnts("cnt", exp_lu, exp_mul, exp_dm, exp_br);

    // Reset asserted while in S_MUL
    @(posedge clk);
    #1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); cyc("rm_entry", O_MULE);
    #2;
    check_val("rm_busy", 64'(hz.out_mul_busy), 64'd1);
    reset = 1'b0;
    #1;
    check_val("rm_async", 64'(outs()), 64'(O_NONE));
    check_cnts("rm_cnt", 0, 0, 0, 0);
    @(posedge clk);
    #2;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("rm_run", O_NONE);
    set_in(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0); cyc("rm_lu", O_LU);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
